// File: rtl/sd_stream_pkg.sv
// Shared constants and FSM state type for the SD multi-block streamer.
package sd_stream_pkg;

    localparam int unsigned BLOCK_BYTES  = 512;
    localparam int unsigned ADDR_W_DEF   = 23;
    localparam int unsigned NUM_BLOCKS_W = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        FILL       = 2'd2,
        DRAIN_WAIT = 2'd3
    } state_t;

endpackage

// File: rtl/sd_bank_ram.sv
// Simple dual-port byte RAM holding both ping-pong banks.
// Ports: clk, rst_n (clears only the read register), write port
// (wr_en/wr_addr/wr_data), read port (rd_en/rd_addr) with rd_data
// registered one cycle after rd_en. Memory contents are never cleared.
module sd_bank_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register; holds its value when rd_en is low so it can act as
    // the stalled output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sd_block_streamer.sv
// Streams a run of SD blocks through two ping-pong banks to a
// valid/ready byte sink.
// Ports: clk, rst_n; start/start_block/num_blocks request a stream;
// sd_ready/sd_trigger/sd_block_addr issue block reads; sd_byte/sd_byte_valid
// carry incoming data; m_data/m_valid/m_ready form the output stream;
// busy, done (pulse) and overrun (sticky) report status.
module sd_block_streamer #(
    parameter int unsigned BLOCK_BYTES = sd_stream_pkg::BLOCK_BYTES,
    parameter int unsigned ADDR_W      = sd_stream_pkg::ADDR_W_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [ADDR_W-1:0]                     start_block,
    input  logic [sd_stream_pkg::NUM_BLOCKS_W-1:0] num_blocks,
    input  logic                                  sd_ready,
    output logic                                  sd_trigger,
    output logic [ADDR_W-1:0]                     sd_block_addr,
    input  logic [7:0]                            sd_byte,
    input  logic                                  sd_byte_valid,
    output logic [7:0]                            m_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overrun
);

    import sd_stream_pkg::*;

    localparam int unsigned IDX_W  = $clog2(BLOCK_BYTES);
    localparam int unsigned RAM_AW = IDX_W + 1;
    localparam int unsigned NB_W   = NUM_BLOCKS_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    state_t            state, state_nxt;
    logic              trig_nxt, done_nxt;
    logic [NB_W-1:0]   issue_left, drain_left;
    logic [ADDR_W-1:0] next_addr;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_bank, rd_bank, out_bank, out_last;
    logic [1:0]        full, full_nxt;
    logic              byte_in, fill_done, fetch, accept, release_bank, start_ok;

    assign start_ok     = (state == IDLE) && start && (num_blocks != '0);
    assign byte_in      = sd_byte_valid && (state == FILL);
    assign fill_done    = byte_in && (wr_idx == LAST_IDX);
    // Output stage is the RAM read register: refill it when empty or taken
    assign fetch        = full[rd_bank] && (!m_valid || m_ready);
    assign accept       = m_valid && m_ready;
    assign release_bank = accept && out_last;

    // Full flags after this cycle; fill and release always hit different banks
    always_comb begin
        full_nxt = full;
        if (fill_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (release_bank) begin
            full_nxt[out_bank] = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control strobes
    always_comb begin
        state_nxt = state;
        trig_nxt  = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_blocks != '0) begin
                        state_nxt = ISSUE;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (sd_ready && !full[wr_bank]) begin
                    trig_nxt  = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                // wr_bank toggles on fill_done, so ~wr_bank is the next write bank
                if (fill_done) begin
                    if ((issue_left != '0) && !full_nxt[~wr_bank]) begin
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = DRAIN_WAIT;
                    end
                end
            end
            DRAIN_WAIT: begin
                if (release_bank && (drain_left == NB_W'(1))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if ((issue_left != '0) && !full_nxt[wr_bank]) begin
                    state_nxt = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_trigger    <= 1'b0;
            sd_block_addr <= '0;
            m_valid       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overrun       <= 1'b0;
            issue_left    <= '0;
            drain_left    <= '0;
            next_addr     <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            out_bank      <= 1'b0;
            out_last      <= 1'b0;
            full          <= '0;
        end else begin
            sd_trigger <= trig_nxt;
            done       <= done_nxt;
            busy       <= (state_nxt != IDLE);
            full       <= full_nxt;

            if (sd_byte_valid && (state != FILL)) begin
                overrun <= 1'b1;
            end

            if (start_ok) begin
                issue_left <= num_blocks;
                drain_left <= num_blocks;
                next_addr  <= start_block;
            end

            if (trig_nxt) begin
                sd_block_addr <= next_addr;
                next_addr     <= next_addr + ADDR_W'(1);
                issue_left    <= issue_left - NB_W'(1);
            end

            if (byte_in) begin
                wr_idx <= fill_done ? '0 : wr_idx + IDX_W'(1);
                if (fill_done) begin
                    wr_bank <= ~wr_bank;
                end
            end

            // Read bank advances at the last fetch so the next block can
            // stream back-to-back; the full flag drops only when that last
            // byte is actually accepted
            if (fetch) begin
                rd_idx   <= (rd_idx == LAST_IDX) ? '0 : rd_idx + IDX_W'(1);
                out_bank <= rd_bank;
                out_last <= (rd_idx == LAST_IDX);
                m_valid  <= 1'b1;
                if (rd_idx == LAST_IDX) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (accept) begin
                m_valid <= 1'b0;
            end

            if (release_bank) begin
                drain_left <= drain_left - NB_W'(1);
            end
        end
    end

    sd_bank_ram #(
        .DEPTH (2 * BLOCK_BYTES),
        .AW    (RAM_AW)
    ) u_bank_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (byte_in),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data (sd_byte),
        .rd_en   (fetch),
        .rd_addr ({rd_bank, rd_idx}),
        .rd_data (m_data)
    );

endmodule

// File: tb/tb_sd_block_streamer.sv
// Bench for sd_block_streamer: SD reader model, ready driver and a
// byte scoreboard, with a table of stream vectors plus directed corner cases.
module tb_sd_block_streamer;

    localparam int BB = 512;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [22:0] start_block;
    logic [15:0] num_blocks;
    logic        sd_ready;
    logic        sd_trigger;
    logic [22:0] sd_block_addr;
    logic [7:0]  sd_byte;
    logic        sd_byte_valid;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        overrun;

    int vectors;
    int miscompares;

    logic [7:0]  byte_q[$];
    logic [22:0] trig_addrs[$];
    int          trig_got[$];
    int          got_bytes;
    int          done_count;
    int          cur_byte;
    int          stray_req;
    int          stray_ack;
    int          ready_mode;

    typedef struct {
        logic [22:0] start_block;
        logic [15:0] num_blocks;
        int          ready_mode;
        int          exp_trigs;
        int          exp_bytes;
        logic [22:0] exp_last_addr;
    } vec_t;

    vec_t vecs[4];

    sd_block_streamer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_block   (start_block),
        .num_blocks    (num_blocks),
        .sd_ready      (sd_ready),
        .sd_trigger    (sd_trigger),
        .sd_block_addr (sd_block_addr),
        .sd_byte       (sd_byte),
        .sd_byte_valid (sd_byte_valid),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [22:0] a, input int i);
        return 8'(a[7:0] * 8'd37 + 8'(i) + 8'(i >> 8) * 8'd91);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sd_trigger"},    64'(sd_trigger),    64'd0);
        check({tag, "_sd_block_addr"}, 64'(sd_block_addr), 64'd0);
        check({tag, "_m_valid"},       64'(m_valid),       64'd0);
        check({tag, "_m_data"},        64'(m_data),        64'd0);
        check({tag, "_busy"},          64'(busy),          64'd0);
        check({tag, "_done"},          64'(done),          64'd0);
        check({tag, "_overrun"},       64'(overrun),       64'd0);
    endtask

    // SD reader model: answers each trigger with one block of pattern bytes
    initial begin : sd_model
        logic [22:0] blk;
        sd_ready      = 1'b1;
        sd_byte_valid = 1'b0;
        sd_byte       = '0;
        cur_byte      = -1;
        forever begin
            @(negedge clk);
            sd_byte_valid = 1'b0;
            if (!rst_n) begin
                sd_ready = 1'b1;
            end else if (stray_ack != stray_req) begin
                sd_byte       = 8'hEE;
                sd_byte_valid = 1'b1;
                stray_ack++;
            end else if (sd_trigger) begin
                blk      = sd_block_addr;
                cur_byte = -1;
                trig_addrs.push_back(blk);
                trig_got.push_back(got_bytes);
                sd_ready = 1'b0;
                for (int i = 0; i < BB; i++) begin
                    @(negedge clk);
                    sd_byte_valid = 1'b0;
                    if (!rst_n) break;
                    if ($urandom_range(0, 7) == 0) begin
                        @(negedge clk);
                        if (!rst_n) break;
                    end
                    sd_byte       = pat(blk, i);
                    sd_byte_valid = 1'b1;
                    byte_q.push_back(sd_byte);
                    cur_byte = i;
                end
                sd_ready = 1'b1;
            end
        end
    end

    // Downstream ready pattern: 0 always, 1 toggle, 2 random, else held low
    initial begin : ready_drv
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: scoreboard, hold-stability and done/busy checks
    initial begin : monitor
        logic       hold_v;
        logic [7:0] hold_d;
        logic [7:0] e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
                byte_q.delete();
            end else begin
                if (hold_v) begin
                    check("hold_valid", 64'(m_valid), 64'd1);
                    check("hold_data",  64'(m_data),  64'(hold_d));
                end
                hold_v = 1'b0;
                if (m_valid && m_ready) begin
                    if (byte_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_byte: got 0x%0h expected no byte", m_data);
                    end else begin
                        e = byte_q.pop_front();
                        check("m_data", 64'(m_data), 64'(e));
                    end
                    got_bytes++;
                end else if (m_valid) begin
                    hold_v = 1'b1;
                    hold_d = m_data;
                end
                if (done) begin
                    done_count++;
                    check("done_busy", 64'(busy), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [22:0] sb, input logic [15:0] nb);
        @(posedge clk);
        #1;
        start       = 1'b1;
        start_block = sb;
        num_blocks  = nb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int dbase);
        bit fin;
        fin = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done_count != dbase) begin
                fin = 1'b1;
                break;
            end
        end
        check({name, "_finished"}, 64'(fin), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_trigs(input string name, input int tbase, input logic [22:0] sb, input int n);
        logic [22:0] a;
        a = sb;
        check({name, "_trig_count"}, 64'(trig_addrs.size() - tbase), 64'(n));
        for (int k = 0; k < n; k++) begin
            if (tbase + k < trig_addrs.size())
                check($sformatf("%s_trig_addr%0d", name, k), 64'(trig_addrs[tbase + k]), 64'(a));
            a = a + 23'd1;
        end
    endtask

    task automatic run_stream(input string name, input vec_t v);
        int tbase, gbase, dbase;
        ready_mode = v.ready_mode;
        tbase = trig_addrs.size();
        gbase = got_bytes;
        dbase = done_count;
        pulse_start(v.start_block, v.num_blocks);
        @(negedge clk);
        check({name, "_busy_high"}, 64'(busy), 64'd1);
        wait_done(name, dbase);
        check({name, "_done_pulses"}, 64'(done_count - dbase), 64'd1);
        check_trigs(name, tbase, v.start_block, v.exp_trigs);
        if (trig_addrs.size() > tbase)
            check({name, "_last_addr"}, 64'(trig_addrs[trig_addrs.size() - 1]), 64'(v.exp_last_addr));
        check({name, "_bytes"},    64'(got_bytes - gbase), 64'(v.exp_bytes));
        check({name, "_leftover"}, 64'(byte_q.size()),     64'd0);
        check({name, "_busy_low"}, 64'(busy),    64'd0);
        check({name, "_m_valid"},  64'(m_valid), 64'd0);
        check({name, "_overrun"},  64'(overrun), 64'd0);
    endtask

    initial begin : main
        int   tbase, gbase, dbase;
        bit   fin;
        vec_t v;

        vecs[0] = '{23'd5,       16'd2, 0, 2, 1024, 23'd6};
        vecs[1] = '{23'h7FFFFF,  16'd2, 0, 2, 1024, 23'h000000};
        vecs[2] = '{23'd100,     16'd1, 1, 1, 512,  23'd100};
        vecs[3] = '{23'h7FFFFE,  16'd3, 2, 3, 1536, 23'h000000};

        rst_n       = 1'b0;
        start       = 1'b0;
        start_block = '0;
        num_blocks  = '0;
        ready_mode  = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_stream($sformatf("vec%0d", i), vecs[i]);
        end

        // Zero-length request: done one cycle later, no trigger
        tbase = trig_addrs.size();
        pulse_start(23'd7, 16'd0);
        @(negedge clk);
        check("zero_done",  64'(done), 64'd1);
        check("zero_busy",  64'(busy), 64'd0);
        @(negedge clk);
        check("zero_done_clear", 64'(done), 64'd0);
        repeat (20) @(negedge clk);
        check("zero_trigs", 64'(trig_addrs.size() - tbase), 64'd0);

        // Sink stalled until both banks fill; start while busy is ignored
        ready_mode = 3;
        tbase = trig_addrs.size();
        gbase = got_bytes;
        dbase = done_count;
        pulse_start(23'd300, 16'd3);
        fin = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (byte_q.size() >= 1024) begin
                fin = 1'b1;
                break;
            end
        end
        check("stall_both_filled", 64'(fin), 64'd1);
        repeat (50) @(negedge clk);
        check("stall_two_trigs",  64'(trig_addrs.size() - tbase), 64'd2);
        check("stall_m_valid",    64'(m_valid),           64'd1);
        check("stall_no_accepts", 64'(got_bytes - gbase), 64'd0);
        pulse_start(23'd999, 16'd5);
        ready_mode = 0;
        wait_done("stall", dbase);
        check("stall_done_pulses", 64'(done_count - dbase), 64'd1);
        check_trigs("stall", tbase, 23'd300, 3);
        check("stall_third_after_512",
              64'((trig_addrs.size() >= tbase + 3) ? (trig_got[tbase + 2] - gbase >= 512) : 1'b0), 64'd1);
        check("stall_bytes", 64'(got_bytes - gbase), 64'd1536);

        // Stray byte while idle
        stray_req++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("stray_m_valid", 64'(m_valid), 64'd0);
        end
        check("stray_overrun", 64'(overrun), 64'd1);

        // Reset in the middle of the second block, then a clean restart
        ready_mode = 0;
        tbase = trig_addrs.size();
        pulse_start(23'd50, 16'd2);
        fin = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ((trig_addrs.size() - tbase == 2) && (cur_byte >= 300)) begin
                fin = 1'b1;
                break;
            end
        end
        check("midrst_reached", 64'(fin), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        v = '{23'd60, 16'd2, 0, 2, 1024, 23'd61};
        run_stream("after_rst", v);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
